// File: rtl/alu_pkg.sv
// Shared ALU constants: widths, opcodes and the scheduler FSM encoding.
package alu_pkg;

  localparam int DATA_W = 65;
  localparam int OP_W   = 9;

  localparam logic [8:0] OP_ADD  = 9'h000;
  localparam logic [8:0] OP_SUB  = 9'h001;
  localparam logic [8:0] OP_MUL  = 9'h002;
  localparam logic [8:0] OP_DIV  = 9'h003;
  localparam logic [8:0] OP_MOD  = 9'h004;
  localparam logic [8:0] OP_AND  = 9'h005;
  localparam logic [8:0] OP_OR   = 9'h006;
  localparam logic [8:0] OP_XOR  = 9'h007;
  localparam logic [8:0] OP_NOT  = 9'h008;
  localparam logic [8:0] OP_SHL  = 9'h009;
  localparam logic [8:0] OP_SHR  = 9'h00a;
  localparam logic [8:0] OP_PASA = 9'h00b;
  localparam logic [8:0] OP_PASB = 9'h00c;
  localparam logic [8:0] OP_NEG  = 9'h00d;
  localparam logic [8:0] OP_INC  = 9'h00e;
  localparam logic [8:0] OP_DEC  = 9'h00f;
  localparam logic [8:0] OP_NOOP = 9'h080;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

endpackage

// File: rtl/alu_sched_rr_arbiter.sv
// Combinational round-robin pick: first set request at or above ptr, wrapping.
module rr_arbiter #(
  parameter int N    = 4,
  parameter int ID_W = 2
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  output logic [N-1:0]    gnt,
  output logic [ID_W-1:0] idx,
  output logic            any
);

  int k;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    k   = 0;
    for (int i = 0; i < N; i++) begin
      k = (int'(ptr) + i) % N;
      if (!any && req[k]) begin
        any    = 1'b1;
        gnt[k] = 1'b1;
        idx    = ID_W'(k);
      end
    end
  end

endmodule

// File: rtl/alu_sched.sv
// Round-robin scheduler sharing one registered-output ALU among N requesters.
module alu_sched #(
  parameter int N      = 4,
  parameter int ID_W   = 2,
  parameter int DATA_W = alu_pkg::DATA_W,
  parameter int OP_W   = alu_pkg::OP_W
) (
  input  logic                c,
  input  logic                rst_n,
  input  logic [N-1:0]        req_valid,
  output logic [N-1:0]        req_ready,
  input  logic [N*OP_W-1:0]   req_op,
  input  logic [N*DATA_W-1:0] req_a,
  input  logic [N*DATA_W-1:0] req_b,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [ID_W-1:0]     rsp_id,
  output logic [DATA_W-1:0]   rsp_data,
  output logic                rsp_err,
  output logic [OP_W-1:0]     alu_instr,
  output logic [DATA_W-1:0]   alu_a,
  output logic [DATA_W-1:0]   alu_b,
  input  logic [DATA_W-1:0]   alu_out,
  output logic                busy
);
  import alu_pkg::*;

  logic [N-1:0][OP_W-1:0]   op_v;
  logic [N-1:0][DATA_W-1:0] a_v, b_v;

  assign op_v = req_op;
  assign a_v  = req_a;
  assign b_v  = req_b;

  state_t            state, nxt;
  logic [ID_W-1:0]   ptr, g_idx;
  logic [N-1:0]      g_1h;
  logic              g_any, g_div0;
  logic [OP_W-1:0]   op_q;
  logic [DATA_W-1:0] a_q, b_q;

  rr_arbiter #(.N(N), .ID_W(ID_W)) u_arb (
    .req(req_valid), .ptr(ptr), .gnt(g_1h), .idx(g_idx), .any(g_any)
  );

  assign g_div0 = (op_v[g_idx] == OP_W'(OP_DIV) || op_v[g_idx] == OP_W'(OP_MOD))
                  && (b_v[g_idx] == '0);

  // Rejected ops skip ISSUE but still pass through WAIT, giving a 2-cycle
  // grant-to-response latency without touching the ALU.
  always_comb begin
    nxt       = state;
    req_ready = '0;
    case (state)
      IDLE:  if (g_any) begin
               req_ready = g_1h;
               nxt       = g_div0 ? WAIT : ISSUE;
             end
      ISSUE: nxt = WAIT;
      WAIT:  nxt = RESP;
      RESP:  if (rsp_ready) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  assign rsp_valid = (state == RESP);
  assign busy      = (state != IDLE);
  assign alu_instr = (state == ISSUE) ? op_q : OP_W'(OP_NOOP);
  assign alu_a     = a_q;
  assign alu_b     = b_q;

  always_ff @(posedge c or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ptr      <= '0;
      op_q     <= OP_W'(OP_NOOP);
      a_q      <= '0;
      b_q      <= '0;
      rsp_id   <= '0;
      rsp_data <= '0;
      rsp_err  <= 1'b0;
    end else begin
      state <= nxt;
      if (state == IDLE && g_any) begin
        op_q     <= op_v[g_idx];
        a_q      <= a_v[g_idx];
        b_q      <= b_v[g_idx];
        rsp_id   <= g_idx;
        rsp_err  <= g_div0;
        rsp_data <= '0;
        ptr      <= (int'(g_idx) == N-1) ? '0 : g_idx + 1'b1;
      end
      if (state == WAIT && !rsp_err) rsp_data <= alu_out;
    end
  end

endmodule
